// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one asynchronous SRAM bus between two requesters.
// Port 0 is the core memory port, port 1 the loader/debug port. Each access
// holds the strobes for ACCESS_CYCLES clocks, then spends one recovery clock
// with a single-cycle ack to the granted port. All outputs are registered.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with port 0 winning ties.
module sram_port_arbiter #(
    parameter int AW            = 21,
    parameter int DW            = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] sram_a,
    input  logic [DW-1:0] sram_dq_i,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    output logic          sram_nce,
    output logic          sram_noe,
    output logic          sram_nwe,
    output logic          busy,
    output logic          gnt_id
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       we_q;
    logic       win;
    logic       win_we;

`ifdef SRAM_ARB_RR_EN
    logic last_gnt;

    // Round-robin pick: on a tie the port not granted last wins.
    always_comb begin
        win = ~req0;
        if (req0 && req1) begin
            win = ~last_gnt;
        end
    end

    // Remember which port received the most recent grant.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (state == ST_IDLE && (req0 || req1)) begin
            last_gnt <= win;
        end
    end
`else
    // Fixed priority: port 0 wins whenever it requests.
    always_comb begin
        win = ~req0;
    end
`endif

    // Write/read direction of the port that would be granted this cycle.
    always_comb begin
        win_we = win ? we1 : we0;
    end

    // Access sequencer: grant, strobe window, recovery with ack.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            sram_a     <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_nce   <= 1'b1;
            sram_noe   <= 1'b1;
            sram_nwe   <= 1'b1;
            busy       <= 1'b0;
            gnt_id     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state     <= ST_ACCESS;
                        cnt       <= CNT_LOAD;
                        busy      <= 1'b1;
                        gnt_id    <= win;
                        we_q      <= win_we;
                        sram_a    <= win ? addr1 : addr0;
                        sram_dq_o <= win ? wdata1 : wdata0;
                        sram_nce  <= 1'b0;
                        if (win_we) begin
                            sram_dq_oe <= 1'b1;
                            sram_nwe   <= 1'b0;
                        end else begin
                            sram_noe <= 1'b0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        state      <= ST_RECOVER;
                        sram_nce   <= 1'b1;
                        sram_noe   <= 1'b1;
                        sram_nwe   <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (!we_q) begin
                            if (gnt_id) begin
                                rdata1 <= sram_dq_i;
                            end else begin
                                rdata0 <= sram_dq_i;
                            end
                        end
                        if (gnt_id) begin
                            ack1 <= 1'b1;
                        end else begin
                            ack0 <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                        // nwe rises one cycle early so address/data are held
                        // through the final strobe cycle.
                        if (we_q && cnt == 4'd1) begin
                            sram_nwe <= 1'b1;
                        end
                    end
                end
                ST_RECOVER: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: two instances (ACCESS_CYCLES 2 and 5),
// each with a transaction-level reference model, per-cycle output compare,
// directed scenarios with literal expectations, and random two-port traffic.
module tb_sram_port_arbiter;

    localparam int AW    = 21;
    localparam int DW    = 8;
    localparam int BUD   = 100;
    localparam int NRAND = 40;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int tests = 0;
    int fails = 0;
    bit done [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : inst
            localparam int AC       = (g == 0) ? 2 : 5;
            localparam int ACK_LAT  = (g == 0) ? 3 : 6;
            localparam int NCE_LIT  = (g == 0) ? 2 : 5;
            localparam int NWE_LIT  = (g == 0) ? 1 : 4;
            localparam int PERIOD   = (g == 0) ? 4 : 7;
            localparam int RR_WAIT  = (g == 0) ? 8 : 14;

            logic          reset;
            logic          req0, we0, req1, we1;
            logic [AW-1:0] addr0, addr1, sram_a;
            logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, sram_dq_i, sram_dq_o;
            logic          ack0, ack1, sram_dq_oe, sram_nce, sram_noe, sram_nwe, busy, gnt_id;
            bit            rand_dq;

            sram_port_arbiter #(.AW(AW), .DW(DW), .ACCESS_CYCLES(AC)) dut (
                .clk_sys   (clk_sys),
                .reset     (reset),
                .req0      (req0),
                .we0       (we0),
                .addr0     (addr0),
                .wdata0    (wdata0),
                .ack0      (ack0),
                .rdata0    (rdata0),
                .req1      (req1),
                .we1       (we1),
                .addr1     (addr1),
                .wdata1    (wdata1),
                .ack1      (ack1),
                .rdata1    (rdata1),
                .sram_a    (sram_a),
                .sram_dq_i (sram_dq_i),
                .sram_dq_o (sram_dq_o),
                .sram_dq_oe(sram_dq_oe),
                .sram_nce  (sram_nce),
                .sram_noe  (sram_noe),
                .sram_nwe  (sram_nwe),
                .busy      (busy),
                .gnt_id    (gnt_id)
            );

            function automatic string nm(input string s);
                return $sformatf("i%0d_%s", g, s);
            endfunction

            // Reference model: one transaction record (start edge, port, dir,
            // addr, data); outputs derive from the edge offset into it.
            int            e = 0;
            bit            tv = 0;
            int            ts = 0;
            logic          tp = 1'b0, twe = 1'b0, lastg = 1'b1;
            logic [AW-1:0] ea = '0;
            logic [DW-1:0] edo = '0;
            logic          eg = 1'b0;
            logic [DW-1:0] erd [2] = '{8'h00, 8'h00};

            initial forever begin
                @(posedge clk_sys);
                e++;
                if (reset) begin
                    tv = 0; ea = '0; edo = '0; eg = 1'b0; lastg = 1'b1;
                    erd[0] = '0; erd[1] = '0;
                end else if (tv) begin
                    if (e == ts + AC) begin
                        if (!twe) erd[tp] = sram_dq_i;
                    end else if (e == ts + AC + 1) begin
                        tv = 0;
                    end
                end else if (req0 || req1) begin
`ifdef SRAM_ARB_RR_EN
                    tp = (req0 && req1) ? !lastg : !req0;
`else
                    tp = !req0;
`endif
                    lastg = tp;
                    tv    = 1;
                    ts    = e;
                    twe   = tp ? we1 : we0;
                    ea    = tp ? addr1 : addr0;
                    edo   = tp ? wdata1 : wdata0;
                    eg    = tp;
                end
            end

            // Per-cycle compare of every output against the model.
            initial forever begin
                logic          x_nce, x_noe, x_nwe, x_oe, x_busy, x_ack0, x_ack1, x_gnt;
                logic [AW-1:0] x_a;
                logic [DW-1:0] x_do, x_r0, x_r1;
                int            k;
                @(negedge clk_sys);
                x_nce = 1; x_noe = 1; x_nwe = 1; x_oe = 0; x_busy = 0;
                x_ack0 = 0; x_ack1 = 0;
                if (reset) begin
                    x_gnt = 0; x_a = '0; x_do = '0; x_r0 = '0; x_r1 = '0;
                end else begin
                    x_gnt = eg; x_a = ea; x_do = edo; x_r0 = erd[0]; x_r1 = erd[1];
                    if (tv) begin
                        k = e - ts;
                        x_busy = 1;
                        if (k < AC) begin
                            x_nce = 0;
                            x_noe = twe;
                            x_nwe = !(twe && k < AC - 1);
                            x_oe  = twe;
                        end else begin
                            x_ack0 = !tp;
                            x_ack1 = tp;
                        end
                    end
                end
                chk(nm("nce"), sram_nce, x_nce);
                chk(nm("noe"), sram_noe, x_noe);
                chk(nm("nwe"), sram_nwe, x_nwe);
                chk(nm("dq_oe"), sram_dq_oe, x_oe);
                chk(nm("busy"), busy, x_busy);
                chk(nm("ack0"), ack0, x_ack0);
                chk(nm("ack1"), ack1, x_ack1);
                chk(nm("gnt_id"), gnt_id, x_gnt);
                chk(nm("sram_a"), sram_a, x_a);
                chk(nm("dq_o"), sram_dq_o, x_do);
                chk(nm("rdata0"), rdata0, x_r0);
                chk(nm("rdata1"), rdata1, x_r1);
            end

            // Randomised read data from the SRAM side when enabled.
            initial forever begin
                @(posedge clk_sys);
                #1;
                if (rand_dq) sram_dq_i = DW'($urandom);
            end

            task automatic raise(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
                if (p == 1) begin
                    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
                end else begin
                    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
                end
            endtask

            // Requester: raise, hold until own ack, drop on the next edge.
            task automatic do_req(input int p, input logic w, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d, output int ack_e);
                ack_e = -1;
                raise(p, w, a, d);
                for (int i = 0; i < BUD && ack_e < 0; i++) begin
                    @(negedge clk_sys);
                    if ((p == 1) ? ack1 : ack0) ack_e = e;
                end
                chk(nm($sformatf("p%0d_ack_seen", p)), ack_e >= 0, 1);
                @(posedge clk_sys);
                #1;
                if (p == 1) req1 = 1'b0; else req0 = 1'b0;
            endtask

            // Single access with bus observation up to the ack.
            task automatic single_access(input int p, input logic w, input logic [AW-1:0] a,
                                         input logic [DW-1:0] d, output int lat, output int nce_n,
                                         output int a_ok, output int nwe_n, output int oe_n,
                                         output int oth);
                lat = -1; nce_n = 0; a_ok = 0; nwe_n = 0; oe_n = 0; oth = 0;
                raise(p, w, a, d);
                for (int i = 1; i <= BUD && lat < 0; i++) begin
                    @(negedge clk_sys);
                    if ((p == 1) ? ack1 : ack0) begin
                        lat = i - 1;
                    end else begin
                        if (!sram_nce) nce_n++;
                        if (!sram_nce && sram_a == a) a_ok++;
                        if (!sram_nwe) nwe_n++;
                        if (sram_dq_oe) oe_n++;
                    end
                    if ((p == 1) ? ack0 : ack1) oth++;
                end
                chk(nm("single_ack_seen"), lat >= 0, 1);
                @(posedge clk_sys);
                #1;
                if (p == 1) req1 = 1'b0; else req0 = 1'b0;
            endtask

            task automatic rnd_port(input int p);
                int ae;
                for (int n = 0; n < NRAND; n++) begin
                    repeat ($urandom_range(1, 4)) @(posedge clk_sys);
                    #1;
                    do_req(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), ae);
                end
            endtask

            initial begin
                int lat, nce_n, a_ok, nwe_n, oe_n, oth, e0, e1, a1, first1, start, acks, n;
                bit drop1, seen;
                int ae [3];
                reset = 1'b1; rand_dq = 0;
                req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
                req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
                sram_dq_i = '0;
                repeat (3) @(posedge clk_sys);
                #1;
                chk(nm("rst_nce"), sram_nce, 1);
                chk(nm("rst_nwe"), sram_nwe, 1);
                chk(nm("rst_busy"), busy, 0);
                chk(nm("rst_ack0"), ack0, 0);
                chk(nm("rst_rdata0"), rdata0, 0);
                chk(nm("rst_sram_a"), sram_a, 0);
                reset = 1'b0;
                @(posedge clk_sys);
                #1;

                // Single read on port 0.
                sram_dq_i = 8'h5A;
                single_access(0, 1'b0, 21'h1ABCD, 8'h00, lat, nce_n, a_ok, nwe_n, oe_n, oth);
                chk(nm("rd_ack_lat"), lat, ACK_LAT);
                chk(nm("rd_nce_cycles"), nce_n, NCE_LIT);
                chk(nm("rd_addr_cycles"), a_ok, NCE_LIT);
                chk(nm("rd_rdata0"), rdata0, 8'h5A);
                chk(nm("rd_ack1_quiet"), oth, 0);

                // Single write on port 1.
                single_access(1, 1'b1, 21'h00010, 8'hC3, lat, nce_n, a_ok, nwe_n, oe_n, oth);
                chk(nm("wr_oe_cycles"), oe_n, NCE_LIT);
                chk(nm("wr_nwe_cycles"), nwe_n, NWE_LIT);
                chk(nm("wr_dq_o"), sram_dq_o, 8'hC3);
                chk(nm("wr_rdata1"), rdata1, 8'h00);

                // Simultaneous requests.
                fork
                    do_req(0, 1'b0, 21'h00100, 8'h00, e0);
                    do_req(1, 1'b0, 21'h00200, 8'h00, e1);
                join
                chk(nm("tie_port0_first"), e0 < e1, 1);
                chk(nm("tie_ack_spacing"), e1 - e0, PERIOD);

                // Port 0 holds request continuously while port 1 waits.
                start = e; a1 = 0; first1 = -1; drop1 = 0;
                raise(0, 1'b0, 21'h00300, 8'h00);
                raise(1, 1'b0, 21'h00400, 8'h00);
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk_sys);
                    if (ack1) begin
                        a1++;
                        if (first1 < 0) first1 = e - start;
                        drop1 = 1;
                    end
                    @(posedge clk_sys);
                    #1;
                    if (drop1) req1 = 1'b0;
                end
`ifdef SRAM_ARB_RR_EN
                chk(nm("rr_port1_served"), first1 >= 0 && first1 <= RR_WAIT, 1);
`else
                chk(nm("fixed_port1_starved"), a1, 0);
`endif
                seen = 0;
                for (int i = 0; i < BUD && !seen; i++) begin
                    @(negedge clk_sys);
                    if (ack0) seen = 1;
                end
                chk(nm("hold_ack0_seen"), seen, 1);
                @(posedge clk_sys);
                #1;
                req0 = 1'b0; req1 = 1'b0;
                @(posedge clk_sys);
                #1;

                // Reset in the second access cycle of a write.
                raise(0, 1'b1, 21'h00123, 8'h3C);
                @(posedge clk_sys);
                @(posedge clk_sys);
                #1;
                chk(nm("mid_nce_active"), sram_nce, 0);
                reset = 1'b1;
                #1;
                chk(nm("mid_rst_nwe"), sram_nwe, 1);
                chk(nm("mid_rst_nce"), sram_nce, 1);
                chk(nm("mid_rst_oe"), sram_dq_oe, 0);
                req0 = 1'b0;
                acks = 0;
                repeat (2) begin
                    @(negedge clk_sys);
                    acks += int'(ack0) + int'(ack1);
                end
                @(posedge clk_sys);
                #1;
                reset = 1'b0;
                repeat (AC + 3) begin
                    @(negedge clk_sys);
                    acks += int'(ack0) + int'(ack1);
                end
                chk(nm("mid_rst_no_ack"), acks, 0);
                chk(nm("mid_rst_busy"), busy, 0);
                @(posedge clk_sys);
                #1;

                // Back-to-back reads on port 0 with a held request.
                rand_dq = 1;
                raise(0, 1'b0, AW'($urandom), 8'h00);
                n = 0;
                for (int i = 0; i < 3 * BUD && n < 3; i++) begin
                    @(negedge clk_sys);
                    if (ack0) begin
                        ae[n] = e;
                        n++;
                    end
                end
                chk(nm("b2b_acks"), n, 3);
                chk(nm("b2b_period_a"), ae[1] - ae[0], PERIOD);
                chk(nm("b2b_period_b"), ae[2] - ae[1], PERIOD);
                @(posedge clk_sys);
                #1;
                req0 = 1'b0;

                // Random traffic on both ports.
                fork
                    rnd_port(0);
                    rnd_port(1);
                join
                repeat (AC + 4) @(posedge clk_sys);
                done[g] = 1;
            end
        end
    endgenerate

    initial begin
        for (int i = 0; i < 60000 && !(done[0] && done[1]); i++) @(posedge clk_sys);
        if (!(done[0] && done[1])) begin
            tests++;
            fails++;
            $display("FAIL run_timeout: done=%0d%0d, required 11", done[0], done[1]);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single asynchronous 8-bit SRAM bus between two requesters.
- Requester 0 is the ZX Next core memory port; requester 1 is the HPS ioctl loader / debug port.
- Sits between the requesters and the SRAM bus driver.
- Sequences each access as a fixed-length SRAM cycle and returns read data with a one-cycle ack pulse.

Parameters:
- AW, 21, address width in bits.
- DW, 8, data width in bits.
- ACCESS_CYCLES, 2, number of clk_sys cycles the strobes are active per access; legal range 2..15.

Ports:
- clk_sys  in  1  system clock (28 MHz).
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 access request, level.
- we0  in  1  requester 0 write enable (1 = write).
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- ack0  out  1  requester 0 completion pulse.
- rdata0  out  DW  requester 0 read data.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for requester 1.
- sram_a  out  AW  SRAM address.
- sram_dq_i  in  DW  SRAM data in.
- sram_dq_o  out  DW  SRAM data out.
- sram_dq_oe  out  1  data bus drive enable.
- sram_nce  out  1  chip enable, active low.
- sram_noe  out  1  output enable, active low.
- sram_nwe  out  1  write enable, active low.
- busy  out  1  high while state is not IDLE.
- gnt_id  out  1  port owning the current or last access.

Behaviour:
- Reset values: ack0 = ack1 = 0; rdata0 = rdata1 = 0; sram_a = 0; sram_dq_o = 0; sram_dq_oe = 0; sram_nce = sram_noe = sram_nwe = 1; busy = 0; gnt_id = 0; state IDLE; counter 0.
- All outputs are registered.
- States: IDLE, ACCESS, RECOVER.
- IDLE:
  - Samples req0/req1 each clock edge.
  - If any request is high: latch the winner's addr/we/wdata into sram_a/sram_dq_o; set gnt_id; load counter = ACCESS_CYCLES-1; go to ACCESS.
  - Arbitration: fixed priority, port 0 wins when both requests are high.
- ACCESS (exactly ACCESS_CYCLES cycles):
  - sram_nce = 0 throughout.
  - Read: sram_noe = 0, sram_dq_oe = 0.
  - Write: sram_dq_oe = 1 for all ACCESS cycles; sram_nwe = 0 for every ACCESS cycle except the last, which gives one cycle of address/data hold.
  - Counter decrements each cycle.
  - At the edge where counter = 0: for a read, capture sram_dq_i into rdata[gnt_id]; assert ack[gnt_id] for the next cycle; go to RECOVER.
- RECOVER (1 cycle):
  - All strobes inactive; sram_dq_oe = 0; ack[gnt_id] = 1.
  - Always go to IDLE next; requests are not sampled in RECOVER.
- Timing: request sampled at edge t gives strobes active in cycles t+1..t+ACCESS_CYCLES, ack high in cycle t+ACCESS_CYCLES+1, IDLE at t+ACCESS_CYCLES+2.
- Minimum back-to-back period is ACCESS_CYCLES+2 cycles.
- Requester handshake rules:
  - Hold req, addr, we and wdata stable until ack.
  - Deassert req no later than the cycle after ack; a req still high in IDLE starts a new access.
- rdata holds its value until the next read ack on the same port. Writes leave rdata unchanged.
- Inputs sampled outside IDLE are ignored; a request dropped before grant is never serviced.
- sram_a and sram_dq_o hold their last values while in IDLE and RECOVER.
- Reset mid-access: asynchronous return to reset values; strobes release immediately; the in-flight access gets no ack.
- Never more than one ack high in a cycle; ack is exactly one cycle wide.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-grant register (reset 1) makes the port not granted last win when both requests are high; a single request is still granted immediately.
- Undefined: fixed priority, port 0 always wins; no last-grant register is built.

Test Plan:
- Single read on port 0, addr 0x1ABCD, SRAM model returns 0x5A:
  - nce/noe low for exactly 2 cycles with sram_a = 0x1ABCD.
  - ack0 high for 1 cycle, 3 cycles after the sampling edge; rdata0 = 0x5A.
  - ack1 stays 0.
- Write on port 1, addr 0x00010, data 0xC3:
  - dq_oe = 1 for 2 cycles; nwe low for the first cycle only; sram_dq_o = 0xC3.
  - ack1 pulses once; rdata1 unchanged.
- req0 and req1 high together, both held until ack:
  - Without the macro: port 0 is serviced, then port 1; grants start 4 cycles apart.
  - With SRAM_ARB_RR_EN: port 0 first after reset, then alternate 0/1/0/1 over 4 accesses.
- Port 0 holds req high continuously while port 1 waits:
  - Without the macro: port 1 is never acked (starvation is documented behaviour).
  - With SRAM_ARB_RR_EN: port 1 is acked within 8 cycles.
- reset asserted in the 2nd ACCESS cycle of a write:
  - nwe/nce/dq_oe go inactive in the same cycle, asynchronously.
  - No ack is issued; after release the block is IDLE with busy = 0.
- ACCESS_CYCLES = 5, back-to-back reads on port 0:
  - nce low for 5 cycles per access.
  - ack period is 7 cycles.
  - rdata0 updates only on ack cycles.
